timer_cnt_ctrl: RTL and testbench

TIMER_CNT_CTRL -- requirements
Module: timer_cnt_ctrl

---
 rtl/timer_cnt_ctrl.sv | 138 +++++++++++++
 tb/tb_timer_cnt_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cnt_ctrl.sv
// 64-bit free-running timer with power-of-two prescaler, bus-loadable count words and debug halt.
// Debug halt logic is present only when TIMER_HALT_EN is defined; otherwise halt_req is ignored.
module timer_cnt_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt_req,
  input  logic        wr_en,
  input  logic [7:0]  reg_sel,
  input  logic [31:0] wdata_counter,
  output logic [63:0] cnt,
  output logic        cnt_tick,
  output logic        cnt_ovf,
  output logic        halted
);

  logic [63:0] cnt_q, cnt_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic        cnt_tick_q, cnt_tick_d;
  logic        cnt_ovf_q, cnt_ovf_d;
  logic        timer_en_q, timer_en_d;
  logic        div_en_q, div_en_d;
  logic [3:0]  div_val_q, div_val_d;

  logic        halt_active;
  logic [3:0]  div_clamp;
  logic [8:0]  div_pow;
  logic [7:0]  pre_target;
  logic        div_bypass;
  logic        div_chg;
  logic        en_fall;
  logic        run;
  logic        tick;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_any;

  logic unused_reg_sel;
  assign unused_reg_sel = ^{reg_sel[7:3], reg_sel[0]};

`ifdef TIMER_HALT_EN
  logic halted_q, halted_d;

  assign halt_active = halt_req & timer_en;
  assign halted_d    = halt_active;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_active     = 1'b0;
  assign halted          = 1'b0;
`endif

  // Exponents above 8 behave as 8 (period 256).
  assign div_clamp  = (div_val > 4'd8) ? 4'd8 : div_val;
  assign div_pow    = 9'd1 << div_clamp;
  assign pre_target = div_pow[7:0] - 8'd1;
  assign div_bypass = ~div_en | (div_clamp == 4'd0);

  assign div_chg = timer_en & ((div_en != div_en_q) | (div_val != div_val_q));
  assign en_fall = timer_en_q & ~timer_en;
  assign run     = timer_en & ~halt_active;
  assign tick    = run & ~div_chg & (div_bypass | (pre_cnt_q == pre_target));

  assign wr_lo  = wr_en & reg_sel[1];
  assign wr_hi  = wr_en & reg_sel[2];
  assign wr_any = wr_lo | wr_hi;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!timer_en) begin
      pre_cnt_d = 8'd0;
    end else if (halt_active) begin
      pre_cnt_d = pre_cnt_q;
    end else if (div_chg || div_bypass || tick) begin
      pre_cnt_d = 8'd0;
    end else begin
      pre_cnt_d = pre_cnt_q + 8'd1;
    end
  end

  // A bus write beats both the disable-clear and a pending tick.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_any) begin
      if (wr_lo) cnt_d[31:0]  = wdata_counter;
      if (wr_hi) cnt_d[63:32] = wdata_counter;
    end else if (en_fall) begin
      cnt_d = 64'd0;
    end else if (tick) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_comb begin
    cnt_tick_d = tick & ~wr_any;
    cnt_ovf_d  = tick & ~wr_any & (&cnt_q);
    timer_en_d = timer_en;
    div_en_d   = div_en;
    div_val_d  = div_val;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q      <= 64'd0;
      pre_cnt_q  <= 8'd0;
      cnt_tick_q <= 1'b0;
      cnt_ovf_q  <= 1'b0;
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= 4'd0;
    end else begin
      cnt_q      <= cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_tick_q <= cnt_tick_d;
      cnt_ovf_q  <= cnt_ovf_d;
      timer_en_q <= timer_en_d;
      div_en_q   <= div_en_d;
      div_val_q  <= div_val_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_tick = cnt_tick_q;
  assign cnt_ovf  = cnt_ovf_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Directed self-checking bench for timer_cnt_ctrl; expectations follow TIMER_HALT_EN when defined.
module tb_timer_cnt_ctrl;

`ifdef TIMER_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        wr_en;
  logic [7:0]  reg_sel;
  logic [31:0] wdata_counter;
  logic [63:0] cnt;
  logic        cnt_tick;
  logic        cnt_ovf;
  logic        halted;

  int n_checks;
  int n_fail;

  timer_cnt_ctrl u_dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .timer_en      (timer_en),
    .div_en        (div_en),
    .div_val       (div_val),
    .halt_req      (halt_req),
    .wr_en         (wr_en),
    .reg_sel       (reg_sel),
    .wdata_counter (wdata_counter),
    .cnt           (cnt),
    .cnt_tick      (cnt_tick),
    .cnt_ovf       (cnt_ovf),
    .halted        (halted)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    sys_rst       = 1'b1;
    timer_en      = 1'b0;
    div_en        = 1'b0;
    div_val       = 4'd0;
    halt_req      = 1'b0;
    wr_en         = 1'b0;
    reg_sel       = 8'h00;
    wdata_counter = 32'h0;
    step(2);
    check_val("rst_cnt", cnt, 64'd0);
    check_val("rst_tick", {63'd0, cnt_tick}, 64'd0);
    check_val("rst_ovf", {63'd0, cnt_ovf}, 64'd0);
    check_val("rst_halted", {63'd0, halted}, 64'd0);
    sys_rst = 1'b0;
    step(1);

    // Undivided counting: one tick per cycle.
    timer_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check_val($sformatf("nodiv_cnt%0d", i), cnt, 64'(i));
      check_val($sformatf("nodiv_tick%0d", i), {63'd0, cnt_tick}, 64'd1);
    end

    // Disable clears the count.
    timer_en = 1'b0;
    step(1);
    check_val("dis_clear_cnt", cnt, 64'd0);
    check_val("dis_clear_tick", {63'd0, cnt_tick}, 64'd0);

    // Divide by 4.
    div_en  = 1'b1;
    div_val = 4'd2;
    step(1);
    timer_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      check_val($sformatf("div4_tick%0d", i), {63'd0, cnt_tick}, (i % 4 == 0) ? 64'd1 : 64'd0);
    end
    check_val("div4_cnt", cnt, 64'd4);

    // Changing the exponent mid-count restarts the prescaler without a tick.
    timer_en = 1'b0;
    step(1);
    timer_en = 1'b1;
    step(2);
    div_val = 4'd1;
    step(1);
    check_val("divchg_cnt0", cnt, 64'd0);
    check_val("divchg_tick0", {63'd0, cnt_tick}, 64'd0);
    step(1);
    check_val("divchg_cnt1", cnt, 64'd0);
    step(1);
    check_val("divchg_cnt2", cnt, 64'd1);

    // Exponent 15 clamps to 8: first tick after 256 cycles.
    timer_en = 1'b0;
    step(1);
    div_val = 4'd15;
    step(1);
    timer_en = 1'b1;
    step(255);
    check_val("clamp_cnt255", cnt, 64'd0);
    step(1);
    check_val("clamp_cnt256", cnt, 64'd1);
    check_val("clamp_tick256", {63'd0, cnt_tick}, 64'd1);

    timer_en = 1'b0;
    step(1);
    div_en  = 1'b0;
    div_val = 4'd0;
    step(1);

    // Wrap from all-ones.
    wr_en         = 1'b1;
    reg_sel       = 8'h02;
    wdata_counter = 32'hFFFF_FFFF;
    step(1);
    reg_sel = 8'h04;
    step(1);
    wr_en   = 1'b0;
    reg_sel = 8'h00;
    check_val("ones_loaded", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    timer_en = 1'b1;
    step(1);
    check_val("wrap_cnt", cnt, 64'd0);
    check_val("wrap_ovf", {63'd0, cnt_ovf}, 64'd1);
    check_val("wrap_tick", {63'd0, cnt_tick}, 64'd1);
    step(1);
    check_val("post_wrap_cnt", cnt, 64'd1);
    check_val("post_wrap_ovf", {63'd0, cnt_ovf}, 64'd0);

    // Write collides with a tick: write wins, no tick pulse.
    wr_en         = 1'b1;
    reg_sel       = 8'h02;
    wdata_counter = 32'h100;
    step(1);
    check_val("wrtick_cnt", cnt, 64'h100);
    check_val("wrtick_tick", {63'd0, cnt_tick}, 64'd0);
    wr_en = 1'b0;
    step(1);
    check_val("wrtick_resume", cnt, 64'h101);
    check_val("wrtick_resume_tick", {63'd0, cnt_tick}, 64'd1);

    // High-word write keeps the low word.
    wr_en         = 1'b1;
    reg_sel       = 8'h04;
    wdata_counter = 32'hABCD;
    step(1);
    check_val("wrhi_cnt", cnt, 64'h0000_ABCD_0000_0101);

    // Write beats the disable-clear.
    timer_en      = 1'b0;
    reg_sel       = 8'h02;
    wdata_counter = 32'h55;
    step(1);
    check_val("wrdis_cnt", cnt, 64'h0000_ABCD_0000_0055);
    wr_en   = 1'b0;
    reg_sel = 8'h00;
    step(1);
    check_val("wrdis_hold", cnt, 64'h0000_ABCD_0000_0055);

    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    check_val("rst2_cnt", cnt, 64'd0);

    // Halt for 7 cycles at count 5.
    timer_en = 1'b1;
    step(5);
    check_val("halt_pre_cnt", cnt, 64'd5);
    halt_req = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check_val($sformatf("halt_cnt%0d", i), cnt, HaltEn ? 64'd5 : 64'(5 + i));
      check_val($sformatf("halt_flag%0d", i), {63'd0, halted}, HaltEn ? 64'd1 : 64'd0);
      check_val($sformatf("halt_tick%0d", i), {63'd0, cnt_tick}, HaltEn ? 64'd0 : 64'd1);
    end
    halt_req = 1'b0;
    step(1);
    check_val("halt_resume_cnt", cnt, HaltEn ? 64'd6 : 64'd13);
    check_val("halt_resume_flag", {63'd0, halted}, 64'd0);
    step(1);
    check_val("halt_resume_cnt2", cnt, HaltEn ? 64'd7 : 64'd14);

    // Reset mid-count and mid-halt overrides a write.
    halt_req      = 1'b1;
    step(1);
    sys_rst       = 1'b1;
    wr_en         = 1'b1;
    reg_sel       = 8'h06;
    wdata_counter = 32'h1234_5678;
    step(1);
    check_val("midrst_cnt", cnt, 64'd0);
    check_val("midrst_tick", {63'd0, cnt_tick}, 64'd0);
    check_val("midrst_ovf", {63'd0, cnt_ovf}, 64'd0);
    check_val("midrst_halted", {63'd0, halted}, 64'd0);
    sys_rst  = 1'b0;
    wr_en    = 1'b0;
    reg_sel  = 8'h00;
    halt_req = 1'b0;
    timer_en = 1'b0;
    step(2);
    check_val("final_cnt", cnt, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
